// File: rtl/prog_loader_pkg.sv
// -----------------------------------------------------------------------------
// prog_loader_pkg
//   Shared definitions for the serial program loader:
//   - default widths for the loader and its input synchronizers;
//   - FSM state encoding (S_IDLE, S_SHIFT, S_WRITE, S_DONE);
//   - ADDR_LAST, the final program address for the default address width.
// -----------------------------------------------------------------------------
package prog_loader_pkg;

  localparam int unsigned DEF_ADDR_W      = 12;
  localparam int unsigned DEF_DATA_W      = 8;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  // Last writable address for the default width; the top derives its own
  // copy from its ADDR_W parameter.
  localparam logic [DEF_ADDR_W-1:0] ADDR_LAST = {DEF_ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage : prog_loader_pkg

// File: rtl/prog_loader_sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
//   Brings one asynchronous level into the clk domain through SYNC_STAGES
//   flip-flops and detects rising/falling edges on the synchronized value.
//
//   Ports:
//     clk      in   system clock
//     reset    in   asynchronous active-low reset
//     d_i      in   asynchronous input level
//     level_o  out  synchronized level
//     rise_o   out  one-cycle pulse on a synchronized 0->1 transition
//     fall_o   out  one-cycle pulse on a synchronized 1->0 transition
//
//   Edges are suppressed until the chain has refilled after reset, so a pin
//   that is already high when reset is released does not look like a rise.
// -----------------------------------------------------------------------------
module sync_edge
  import prog_loader_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  // Shifts in ones after reset; the top bit marks that both the level and
  // its one-cycle-delayed copy reflect the real pin.
  logic [SYNC_STAGES:0]   arm_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      arm_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      arm_q  <= {arm_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = arm_q[SYNC_STAGES] &  sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o  = arm_q[SYNC_STAGES] & ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule : sync_edge

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//   Serial program loader: write side of the CPU program RAM. Bytes arrive
//   MSB first on a slow sclk/sdata link and are written sequentially from
//   address 0 while the CPU is held in reset.
//
//   Ports:
//     clk         in   system clock (only clock)
//     reset       in   asynchronous active-low reset
//     load_en     in   async level, high = load session active
//     sclk        in   async serial clock, data sampled on its rise
//     sdata       in   async serial data, MSB first
//     prog_we     out  one-cycle program RAM write strobe
//     prog_addr   out  write address (saturates at the last address)
//     prog_wdata  out  write data, valid with prog_we (0 otherwise)
//     cpu_hold    out  high while a session is in progress
//     load_done   out  one-cycle pulse at the end of a session
//     overflow    out  sticky: a byte arrived after the last address was written
//     checksum    out  mod-256 sum of written bytes
//
//   Build option: define PROG_LOADER_CHECKSUM_EN to include the checksum
//   accumulator; otherwise checksum is tied to 0.
// -----------------------------------------------------------------------------
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic              sclk,
  input  logic              sdata,
  output logic              prog_we,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [DATA_W-1:0] prog_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              overflow,
  output logic [DATA_W-1:0] checksum
);

  localparam int unsigned       CNT_W       = $clog2(DATA_W);
  localparam logic [ADDR_W-1:0] ADDR_LAST_W = {ADDR_W{1'b1}};
  localparam logic [CNT_W-1:0]  BIT_LAST    = CNT_W'(DATA_W - 1);

  // ---------------------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------------------
  logic le_rise, le_fall, le_level_unused;
  logic sclk_rise, sclk_level_unused, sclk_fall_unused;
  logic sdata_lvl, sdata_rise_unused, sdata_fall_unused;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_load_en (
    .clk     (clk),
    .reset   (reset),
    .d_i     (load_en),
    .level_o (le_level_unused),
    .rise_o  (le_rise),
    .fall_o  (le_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk     (clk),
    .reset   (reset),
    .d_i     (sclk),
    .level_o (sclk_level_unused),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall_unused)
  );

  // Same depth as sclk, so sdata is seen exactly as it was at the sclk edge.
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdata (
    .clk     (clk),
    .reset   (reset),
    .d_i     (sdata),
    .level_o (sdata_lvl),
    .rise_o  (sdata_rise_unused),
    .fall_o  (sdata_fall_unused)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e              state_q,    state_d;
  logic [DATA_W-1:0]   shreg_q,    shreg_d;
  logic [CNT_W-1:0]    bitcnt_q,   bitcnt_d;
  logic [ADDR_W-1:0]   addr_q,     addr_d;
  logic                full_q,     full_d;
  logic                ovf_q,      ovf_d;
  // A load_en fall that coincided with the final bit of a byte: the byte is
  // written first and the session ends right after.
  logic                dpend_q,    dpend_d;
  // A load_en rise seen during DONE, replayed from IDLE.
  logic                restart_q,  restart_d;
  logic                we_c, done_c;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]   csum_q,     csum_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      addr_q    <= '0;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
      dpend_q   <= 1'b0;
      restart_q <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bitcnt_q  <= bitcnt_d;
      addr_q    <= addr_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
      dpend_q   <= dpend_d;
      restart_q <= restart_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    addr_d    = addr_q;
    full_d    = full_q;
    ovf_d     = ovf_q;
    dpend_d   = dpend_q;
    restart_d = restart_q;
    we_c      = 1'b0;
    done_c    = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (le_rise || restart_q) begin
          state_d   = S_SHIFT;
          shreg_d   = '0;
          bitcnt_d  = '0;
          addr_d    = '0;
          full_d    = 1'b0;
          ovf_d     = 1'b0;
          dpend_d   = 1'b0;
          restart_d = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d    = '0;
`endif
        end
      end

      S_SHIFT: begin
        if (sclk_rise) begin
          shreg_d = {shreg_q[DATA_W-2:0], sdata_lvl};
        end
        if (sclk_rise && (bitcnt_q == BIT_LAST)) begin
          // Byte complete: write takes priority over a simultaneous end.
          state_d  = S_WRITE;
          bitcnt_d = '0;
          dpend_d  = le_fall;
        end else if (le_fall) begin
          // Session ends; any partial byte is discarded.
          state_d  = S_DONE;
          bitcnt_d = '0;
        end else if (sclk_rise) begin
          bitcnt_d = bitcnt_q + CNT_W'(1);
        end
      end

      S_WRITE: begin
        if (!full_q) begin
          we_c = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d = csum_q + shreg_q;
`endif
          // Saturate at the last address; full blocks any later write.
          if (addr_q == ADDR_LAST_W) begin
            full_d = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end else begin
          ovf_d = 1'b1;
        end
        dpend_d = 1'b0;
        state_d = (dpend_q || le_fall) ? S_DONE : S_SHIFT;
      end

      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
        if (le_rise) begin
          restart_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign prog_we    = we_c;
  assign prog_addr  = addr_q;
  assign prog_wdata = we_c ? shreg_q : '0;
  assign cpu_hold   = (state_q != S_IDLE);
  assign load_done  = done_c;
  assign overflow   = ovf_q;

`ifdef PROG_LOADER_CHECKSUM_EN
  assign checksum   = csum_q;
`else
  assign checksum   = '0;
`endif

endmodule : prog_loader

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//   Directed bench for prog_loader (ADDR_W=4 so overflow is reachable).
//   Expected writes are queued as bytes are issued; a negedge monitor pops
//   and compares on every prog_we.
// -----------------------------------------------------------------------------
module tb_prog_loader;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load_en = 1'b0;
  logic          sclk = 1'b0;
  logic          sdata = 1'b0;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] prog_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          overflow;
  logic [DW-1:0] checksum;

  int checks = 0;
  int errors = 0;

  logic [AW+DW-1:0] exp_q[$];
  int        exp_addr = 0;
  bit        exp_full = 1'b0;
  logic [7:0] exp_csum = 8'h00;

  int cyc      = 0;
  int done_cnt = 0;
  int we_cyc   = -100;
  int done_cyc = -100;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  prog_loader #(.ADDR_W(AW), .DATA_W(DW), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_en    (load_en),
    .sclk       (sclk),
    .sdata      (sdata),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .overflow   (overflow),
    .checksum   (checksum)
  );

  // Monitor: one line per write transaction.
  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (load_done) begin
      done_cnt++;
      done_cyc = cyc;
      $display("[%0t] load_done", $time);
    end
    if (prog_we) begin
      we_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                 prog_addr, prog_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({prog_addr, prog_wdata} !== e || cpu_hold !== 1'b1) begin
          errors++;
          $display("FAIL write: got addr %0h data %0h hold %b, expected addr %0h data %0h hold 1",
                   prog_addr, prog_wdata, cpu_hold, e[AW+DW-1:DW], e[DW-1:0]);
        end else begin
          $display("[%0t] write addr %0h data %0h ok", $time, prog_addr, prog_wdata);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("[%0t] check %s = %0h ok", $time, name, act);
    end
  endtask

  function automatic logic [7:0] exp_ck();
`ifdef PROG_LOADER_CHECKSUM_EN
    return exp_csum;
`else
    return 8'h00;
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_byte(input logic [7:0] b);
    if (!exp_full) begin
      exp_q.push_back({exp_addr[AW-1:0], b});
      exp_csum = exp_csum + b;
      if (exp_addr == (1 << AW) - 1) exp_full = 1'b1;
      else exp_addr++;
    end
  endtask

  task automatic send_bit(input logic b);
    sclk  = 1'b0;
    sdata = b;
    tick(4);
    sclk  = 1'b1;
    tick(4);
  endtask

  task automatic send_byte(input logic [7:0] b);
    expect_byte(b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic start_session();
    exp_addr = 0;
    exp_full = 1'b0;
    exp_csum = 8'h00;
    load_en  = 1'b1;
    tick(6);
  endtask

  task automatic end_session();
    sclk    = 1'b0;
    load_en = 1'b0;
    tick(8);
  endtask

  initial begin
    int d0;
    logic [7:0] b4;

    // Reset state
    tick(3);
    check("rst_prog_we",   {31'd0, prog_we},   32'd0);
    check("rst_prog_addr", {28'd0, prog_addr}, 32'd0);
    check("rst_cpu_hold",  {31'd0, cpu_hold},  32'd0);
    check("rst_overflow",  {31'd0, overflow},  32'd0);
    check("rst_checksum",  {24'd0, checksum},  32'd0);
    reset = 1'b1;
    tick(6);

    // 1: two bytes
    start_session();
    check("t1_hold_start", {31'd0, cpu_hold}, 32'd1);
    send_byte(8'hA5);
    send_byte(8'h3C);
    check("t1_hold_mid", {31'd0, cpu_hold}, 32'd1);
    d0 = done_cnt;
    end_session();
    check("t1_done_pulses", done_cnt, d0 + 1);
    check("t1_hold_end",    {31'd0, cpu_hold}, 32'd0);
    check("t1_checksum",    {24'd0, checksum}, {24'd0, exp_ck()});

    // 2: one byte then a partial byte
    start_session();
    send_byte(8'h12);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    d0 = done_cnt;
    end_session();
    check("t2_done_pulses", done_cnt, d0 + 1);
    check("t2_prog_addr",   {28'd0, prog_addr}, 32'd1);
    check("t2_hold_end",    {31'd0, cpu_hold}, 32'd0);

    // 3: overflow with 17 bytes
    start_session();
    for (int i = 0; i < 16; i++) send_byte(8'(i * 17));
    check("t3_ovf_before", {31'd0, overflow},  32'd0);
    check("t3_addr_sat",   {28'd0, prog_addr}, 32'd15);
    send_byte(8'hEE);
    check("t3_ovf_after",  {31'd0, overflow},  32'd1);
    check("t3_addr_after", {28'd0, prog_addr}, 32'd15);
    end_session();
    check("t3_ovf_sticky", {31'd0, overflow}, 32'd1);
    check("t3_checksum",   {24'd0, checksum}, {24'd0, exp_ck()});

    // 4: final sclk rise coincides with load_en fall
    start_session();
    check("t4_ovf_cleared", {31'd0, overflow}, 32'd0);
    b4 = 8'h7E;
    expect_byte(b4);
    for (int i = 7; i >= 1; i--) send_bit(b4[i]);
    sclk  = 1'b0;
    sdata = b4[0];
    tick(4);
    d0 = done_cnt;
    sclk    = 1'b1;
    load_en = 1'b0;
    tick(8);
    check("t4_done_pulses",   done_cnt, d0 + 1);
    check("t4_done_after_we", done_cyc - we_cyc, 32'd1);
    check("t4_prog_addr",     {28'd0, prog_addr}, 32'd1);

    // 6: sub-cycle sclk glitches
    start_session();
    sdata = 1'b1;
    repeat (8) begin
      sclk = 1'b1;
      #3;
      sclk = 1'b0;
      tick(1);
    end
    tick(8);
    check("t6_addr_no_write", {28'd0, prog_addr}, 32'd0);
    send_byte(8'h5A);
    end_session();
    check("t6_addr_after", {28'd0, prog_addr}, 32'd1);

    // 5: reset mid-byte
    start_session();
    send_byte(8'hC3);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("t5_rst_hold",  {31'd0, cpu_hold},  32'd0);
    check("t5_rst_addr",  {28'd0, prog_addr}, 32'd0);
    check("t5_rst_we",    {31'd0, prog_we},   32'd0);
    check("t5_rst_done",  {31'd0, load_done}, 32'd0);
    check("t5_rst_wdata", {24'd0, prog_wdata}, 32'd0);
    tick(3);
    reset = 1'b1;
    tick(20);
    check("t5_stay_idle", {31'd0, cpu_hold}, 32'd0);
    load_en = 1'b0;
    tick(6);
    start_session();
    check("t5_new_session", {31'd0, cpu_hold}, 32'd1);
    send_byte(8'h81);
    d0 = done_cnt;
    end_session();
    check("t5_done_pulses", done_cnt, d0 + 1);
    check("t5_prog_addr",   {28'd0, prog_addr}, 32'd1);

    check("all_writes_seen", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_prog_loader
